counter_sequencer: RTL

Programmable run controller for the team's 4-bit up-counter datapath. It starts, pauses, stops and rate-divides a counter that wraps at a programmable terminal value, in one-shot or periodic mode. It flags each terminal count with a one-cycle `done` pulse. It sits between software/top-level control strobes and the counter, replacing the free-running counter where a bounded or timed count is needed.

---
 rtl/counter_pkg.sv | 14 +
 rtl/count_core.sv | 34 +++
 rtl/counter_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types and default sizes for the counter run controller and its count register.
package counter_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_PRE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/count_core.sv
// Count register: synchronous clear, enabled increment, and wrap or hold at the terminal value.
module count_core
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             hold,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    assign terminal = (count == limit);

    // At the terminal value an enabled step wraps to zero, or stays put when hold is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (!terminal) begin
                count <= count + 1'b1;
            end else if (!hold) begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Run controller for the up-counter: start/stop/pause, prescaled stepping, one-shot or periodic wrap.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] Output,
    output logic             busy,
    output logic             done
);

    state_t             state;
    logic [PRE_W-1:0]   prescaler;
    logic [PRE_W-1:0]   pre_l;
    logic [WIDTH-1:0]   limit_l;
    logic               mode_l;
    logic               armed;
    logic               active;
    logic               tick;
    logic               terminal;
    logic               core_clear;
    logic               core_enable;

    // An edge leaving PAUSE with pause low does a normal RUN step, so each paused cycle costs exactly one.
    assign armed       = (state == IDLE) || (state == DONE);
    assign active      = ((state == RUN) || (state == PAUSE)) && !pause && !stop;
    assign tick        = (prescaler == pre_l);
    assign core_clear  = stop || (armed && start);
    assign core_enable = active && tick;

    count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (Reset_n),
        .clear    (core_clear),
        .enable   (core_enable),
        .hold     (!mode_l),
        .limit    (limit_l),
        .count    (Output),
        .terminal (terminal)
    );

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            prescaler <= '0;
            pre_l     <= '0;
            limit_l   <= '0;
            mode_l    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state     <= IDLE;
                prescaler <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            limit_l   <= limit;
                            pre_l     <= prescale;
                            mode_l    <= mode;
                            prescaler <= '0;
                            state     <= RUN;
                            busy      <= 1'b1;
                        end
                    end
                    RUN, PAUSE: begin
                        if (pause) begin
                            state <= PAUSE;
                        end else if (tick) begin
                            prescaler <= '0;
                            state     <= RUN;
                            if (terminal) begin
                                done <= 1'b1;
                                if (!mode_l) begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                end
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                            state     <= RUN;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
